viterbi_k3_decoder: RTL

//  Hard-decision Viterbi decoder. Rate 1/2, K=3, generators G0=7, G1=5 (octal).

---
 rtl/viterbi_pkg.sv | 29 ++
 rtl/viterbi_k3_decoder_if.sv | 25 ++
 rtl/viterbi_acs.sv | 21 ++
 rtl/viterbi_k3_decoder.sv | 134 +++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared constants, types and helpers for the rate-1/2 K=3 (7,5) Viterbi decoder.
package viterbi_pkg;

  localparam logic [2:0] G0 = 3'o7;
  localparam logic [2:0] G1 = 3'o5;

  // Encoder state {b[n-1], b[n-2]}
  typedef logic [1:0] state_t;

  typedef enum logic [1:0] {
    S_ACS,
    S_TRACE,
    S_HOLD
  } fsm_t;

  // Code symbol {g0,g1} emitted when bit b enters an encoder sitting in state s
  function automatic logic [1:0] exp_sym(state_t s, logic b);
    logic [2:0] taps;
    taps = {b, s};
    return {^(taps & G0), ^(taps & G1)};
  endfunction

  function automatic logic [1:0] hamming2(logic [1:0] a, logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {x[1] & x[0], x[1] ^ x[0]};
  endfunction

endpackage

// File: rtl/viterbi_k3_decoder_if.sv
// Symbol-in / frame-out bus of the Viterbi decoder; master drives symbols and acks.
interface viterbi_k3_decoder_if #(
  parameter int FRAME_BITS = 32,
  parameter int PM_W       = 8
) ();

  logic                  sym_valid;
  logic                  sym_ready;
  logic [1:0]            sym;
  logic                  frame_valid;
  logic                  frame_ack;
  logic [FRAME_BITS-1:0] frame_data;
  logic [PM_W-1:0]       best_metric;

  modport master (
    output sym_valid, sym, frame_ack,
    input  sym_ready, frame_valid, frame_data, best_metric
  );

  modport slave (
    input  sym_valid, sym, frame_ack,
    output sym_ready, frame_valid, frame_data, best_metric
  );

endinterface

// File: rtl/viterbi_acs.sv
// One add-compare-select cell: pm_a/bm_a is the predecessor with LSB 0, which wins ties.
module viterbi_acs #(
  parameter int PM_W = 8
) (
  input  logic [PM_W-1:0] pm_a,
  input  logic [PM_W-1:0] pm_b,
  input  logic [1:0]      bm_a,
  input  logic [1:0]      bm_b,
  output logic [PM_W-1:0] pm_new,
  output logic            dec
);

  logic [PM_W-1:0] sum_a;
  logic [PM_W-1:0] sum_b;

  assign sum_a  = pm_a + PM_W'(bm_a);
  assign sum_b  = pm_b + PM_W'(bm_b);
  assign dec    = (sum_b < sum_a);
  assign pm_new = dec ? sum_b : sum_a;

endmodule

// File: rtl/viterbi_k3_decoder.sv
// Hard-decision K=3 Viterbi decoder with full-frame traceback.
// Define VITERBI_TAIL_EN for zero-tailed frames (traceback from state 0).
module viterbi_k3_decoder
  import viterbi_pkg::*;
#(
  parameter int FRAME_BITS = 32,
  parameter int PM_W       = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  input logic                 flush,
  viterbi_k3_decoder_if.slave bus
);

`ifdef VITERBI_TAIL_EN
  localparam int NSYM = FRAME_BITS + 2;
`else
  localparam int NSYM = FRAME_BITS;
`endif
  localparam int CNT_W = $clog2(NSYM + 1);
  localparam int IDX_W = $clog2(NSYM);
  localparam int FD_W  = $clog2(FRAME_BITS);
  localparam logic [PM_W-1:0] PM_INIT = {2'b01, {(PM_W-2){1'b0}}};

  if (PM_W < $clog2(2 * FRAME_BITS) + 2) begin : g_pm_w_check
    $error("PM_W too narrow for FRAME_BITS");
  end

  fsm_t             state, state_nxt;
  logic             alive;
  logic [PM_W-1:0]  pm     [4];
  logic [PM_W-1:0]  pm_new [4];
  logic [3:0]       dec;
  logic [3:0]       surv   [NSYM];
  logic [CNT_W-1:0] n;
  state_t           tstate;
  state_t           start_s;
  logic [PM_W-1:0]  start_pm;
  logic             sym_fire, last_sym, pm_reinit, trace_setup;

  assign bus.sym_ready   = alive && (state == S_ACS);
  assign bus.frame_valid = (state == S_HOLD);
  assign sym_fire        = bus.sym_valid && bus.sym_ready;
  assign last_sym        = sym_fire && (n == CNT_W'(NSYM - 1));
  assign pm_reinit       = flush || ((state == S_HOLD) && bus.frame_ack);
  // n parks at NSYM for one cycle after the last symbol while the start state is chosen
  assign trace_setup     = (n == CNT_W'(NSYM));

  // Successor s is entered with input bit s[1] from predecessors {s[0],0} and {s[0],1}
  for (genvar s = 0; s < 4; s++) begin : g_acs
    localparam state_t PA   = state_t'(2 * (s % 2));
    localparam state_t PB   = state_t'(2 * (s % 2) + 1);
    localparam logic   B_IN = (s >= 2);

    viterbi_acs #(.PM_W(PM_W)) u_acs (
      .pm_a   (pm[PA]),
      .pm_b   (pm[PB]),
      .bm_a   (hamming2(bus.sym, exp_sym(PA, B_IN))),
      .bm_b   (hamming2(bus.sym, exp_sym(PB, B_IN))),
      .pm_new (pm_new[s]),
      .dec    (dec[s])
    );
  end

`ifdef VITERBI_TAIL_EN
  assign start_s  = '0;
  assign start_pm = pm[0];
`else
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    start_s  = '0;
    start_pm = pm[0];
    for (int i = 1; i < 4; i++) begin
      if (pm[i] < start_pm) begin
        start_s  = state_t'(i);
        start_pm = pm[i];
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_ACS;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_ACS:   if (last_sym) state_nxt = S_TRACE;
      S_TRACE: if (!trace_setup && n == '0) state_nxt = S_HOLD;
      S_HOLD:  if (bus.frame_ack) state_nxt = S_ACS;
      default: state_nxt = S_ACS;
    endcase
    if (flush) state_nxt = S_ACS;
  end

  // NOTE: survivor rows carry no reset; every row is rewritten before traceback reads it.
  always_ff @(posedge clk) begin
    if (sym_fire) surv[n[IDX_W-1:0]] <= dec;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive           <= 1'b0;
      n               <= '0;
      tstate          <= '0;
      bus.frame_data  <= '0;
      bus.best_metric <= '0;
      for (int i = 0; i < 4; i++) pm[i] <= (i == 0) ? '0 : PM_INIT;
    end else begin
      alive <= 1'b1;
      if (pm_reinit) begin
        n <= '0;
        for (int i = 0; i < 4; i++) pm[i] <= (i == 0) ? '0 : PM_INIT;
      end else if (sym_fire) begin
        pm <= pm_new;
        n  <= n + CNT_W'(1);
      end else if (state == S_TRACE) begin
        if (trace_setup) begin
          tstate          <= start_s;
          bus.best_metric <= start_pm;
          n               <= CNT_W'(NSYM - 1);
        end else begin
          if (n < CNT_W'(FRAME_BITS)) bus.frame_data[n[FD_W-1:0]] <= tstate[1];
          tstate <= {tstate[0], surv[n[IDX_W-1:0]][tstate]};
          if (n != '0) n <= n - CNT_W'(1);
        end
      end
    end
  end

endmodule
